// File: rtl/fw_ram_scrubber_pkg.sv
// Shared definitions for the FW RAM scrubber: FSM encoding, byte-enable
// constants and the default fill pattern.
package fw_ram_scrubber_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

  localparam logic [3:0]  WE_ALL       = 4'hf;
  localparam logic [3:0]  WE_NONE      = 4'h0;
  localparam logic [31:0] FILL_DEFAULT = 32'h0;

endpackage

// File: rtl/fw_ram_scrubber_timeout.sv
// Ready watchdog: counts wait cycles without an acknowledge and flags the
// cycle in which the budget of TIMEOUT wait cycles is used up.
module fw_ram_scrubber_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt <= 4'h0;
    else if (clear)  cnt <= 4'h0;
    else if (enable) cnt <= cnt + 4'h1;
  end

  // Combinational so the FSM can leave on the TIMEOUT-th silent wait cycle.
  assign expired = enable && (cnt == 4'(TIMEOUT - 1));

endmodule

// File: rtl/fw_ram_scrubber.sv
// FW RAM scrubber: fills every word with FILL_VALUE, reads each back and
// reports the first failing address (mismatch or missing acknowledge).
module fw_ram_scrubber
  import fw_ram_scrubber_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DEPTH      = 256,
  parameter logic [31:0] FILL_VALUE = FILL_DEFAULT,
  parameter int          TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  ram_cs,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_write_data,
  input  logic [31:0]           ram_read_data,
  input  logic                  ram_ready
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  in_wait;
  logic                  last;
  logic                  expired;

  assign in_wait  = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
  assign last     = (addr == ADDR_WIDTH'(DEPTH - 1));
  assign addr_nxt = addr + ADDR_WIDTH'(1);

  fw_ram_scrubber_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!in_wait),
    .enable  (in_wait && !ram_ready),
    .expired (expired)
  );

  // Outputs are loaded on the transition into a state so every output is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      addr           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_addr       <= '0;
      ram_cs         <= 1'b0;
      ram_we         <= WE_NONE;
      ram_address    <= '0;
      ram_write_data <= '0;
    end else begin
      done           <= 1'b0;
      ram_cs         <= 1'b0;
      ram_we         <= WE_NONE;
      ram_write_data <= '0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            error          <= 1'b0;
            err_addr       <= '0;
            addr           <= '0;
            busy           <= 1'b1;
            ram_cs         <= 1'b1;
            ram_we         <= WE_ALL;
            ram_address    <= '0;
            ram_write_data <= FILL_VALUE;
            state          <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: state <= ST_WR_WAIT;
        ST_WR_WAIT: begin
          if (ram_ready) begin
            ram_cs <= 1'b1;
            if (last) begin
              addr        <= '0;
              ram_address <= '0;
              state       <= ST_RD_REQ;
            end else begin
              addr           <= addr_nxt;
              ram_address    <= addr_nxt;
              ram_we         <= WE_ALL;
              ram_write_data <= FILL_VALUE;
              state          <= ST_WR_REQ;
            end
          end else if (expired) begin
            if (!error) begin
              error    <= 1'b1;
              err_addr <= addr;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FINISH;
          end
        end
        ST_RD_REQ: state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (ram_ready) begin
            if ((ram_read_data != FILL_VALUE) && !error) begin
              error    <= 1'b1;
              err_addr <= addr;
            end
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              addr        <= addr_nxt;
              ram_address <= addr_nxt;
              ram_cs      <= 1'b1;
              state       <= ST_RD_REQ;
            end
          end else if (expired) begin
            if (!error) begin
              error    <= 1'b1;
              err_addr <= addr;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fw_ram_scrubber.sv
// Bench for fw_ram_scrubber: a timeline model built from per-access responder
// delays predicts every output cycle by cycle for a DEPTH=4 and a DEPTH=256 DUT.
module tb_fw_ram_scrubber;

  localparam int          TO    = 15;
  localparam int          MAXC  = 1200;
  localparam logic [31:0] FILLB = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_drv = 1'b0;
  logic        sel = 1'b0;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_read_data = 32'h0;

  logic       a_busy, a_done, a_error, a_cs, b_busy, b_done, b_error, b_cs;
  logic [7:0] a_ea, a_addr, b_ea, b_addr;
  logic [3:0] a_we, b_we;
  logic [31:0] a_wd, b_wd;

  fw_ram_scrubber #(.ADDR_WIDTH(8), .DEPTH(4), .FILL_VALUE(32'h0), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_drv & ~sel), .busy(a_busy), .done(a_done),
    .error(a_error), .err_addr(a_ea), .ram_cs(a_cs), .ram_we(a_we), .ram_address(a_addr),
    .ram_write_data(a_wd), .ram_read_data(ram_read_data), .ram_ready(ram_ready & ~sel));

  fw_ram_scrubber #(.ADDR_WIDTH(8), .DEPTH(256), .FILL_VALUE(FILLB), .TIMEOUT(TO)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_drv & sel), .busy(b_busy), .done(b_done),
    .error(b_error), .err_addr(b_ea), .ram_cs(b_cs), .ram_we(b_we), .ram_address(b_addr),
    .ram_write_data(b_wd), .ram_read_data(ram_read_data), .ram_ready(ram_ready & sel));

  logic        busy, done, error, ram_cs;
  logic [7:0]  err_addr, ram_address;
  logic [3:0]  ram_we;
  logic [31:0] ram_write_data;
  assign busy           = sel ? b_busy : a_busy;
  assign done           = sel ? b_done : a_done;
  assign error          = sel ? b_error : a_error;
  assign err_addr       = sel ? b_ea : a_ea;
  assign ram_cs         = sel ? b_cs : a_cs;
  assign ram_we         = sel ? b_we : a_we;
  assign ram_address    = sel ? b_addr : a_addr;
  assign ram_write_data = sel ? b_wd : a_wd;

  // Model timeline and stimulus plan
  bit          e_cs [MAXC], e_busy [MAXC], e_done [MAXC], e_err [MAXC];
  logic [3:0]  e_we [MAXC];
  logic [7:0]  e_addr [MAXC], e_ea [MAXC];
  logic [31:0] e_wd [MAXC];
  int          dly [512];
  logic [31:0] corr [256];
  logic [31:0] mem [256];
  bit          m_err [2];
  logic [7:0]  m_ea [2];

  int   n_vec = 0, n_bad = 0;
  int   pend, kacc;
  logic [7:0] paddr;
  bit   pwr, stray_en;

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h", nm, t, act, exp);
    end
  endtask

  // Each access: select at c, acknowledge at c+d, next select (or done) at c+d+1.
  // No acknowledge within TO wait cycles ends the sweep at c+TO+1.
  task automatic build_model(input int depth, input logic [31:0] fill, output int f);
    int c, err_from, ea;
    bit err;
    c = 1; err = 0; ea = 0; err_from = -1; f = 0;
    for (int t = 0; t < MAXC; t++) begin
      e_cs[t] = 0; e_we[t] = 4'h0; e_addr[t] = 8'h0; e_wd[t] = 32'h0;
    end
    for (int k = 0; k < 2 * depth; k++) begin
      int a, d;
      bit wr;
      a = k % depth; wr = (k < depth); d = dly[k];
      e_cs[c] = 1; e_we[c] = wr ? 4'hf : 4'h0; e_addr[c] = 8'(a); e_wd[c] = wr ? fill : 32'h0;
      if (d == 0 || d > TO) begin
        if (!err) begin err = 1; ea = a; err_from = c + TO + 1; end
        f = c + TO + 1;
        break;
      end
      if (!wr && corr[a] != 0 && !err) begin err = 1; ea = a; err_from = c + d + 1; end
      c = c + d + 1;
      f = c;
    end
    for (int t = 0; t < MAXC; t++) begin
      e_busy[t] = (t >= 1) && (t < f);
      e_done[t] = (t == f);
      if (t == 0) begin
        e_err[t] = m_err[sel]; e_ea[t] = m_ea[sel];
      end else begin
        e_err[t] = (err_from >= 0) && (t >= err_from);
        e_ea[t]  = e_err[t] ? 8'(ea) : 8'h0;
      end
    end
    m_err[sel] = err;
    m_ea[sel]  = 8'(ea);
  endtask

  task automatic compare(input int t);
    chk("cs", t, 32'(ram_cs), 32'(e_cs[t]));
    chk("we", t, 32'(ram_we), 32'(e_we[t]));
    chk("wdata", t, ram_write_data, e_wd[t]);
    if (e_cs[t]) chk("address", t, 32'(ram_address), 32'(e_addr[t]));
    chk("busy", t, 32'(busy), 32'(e_busy[t]));
    chk("done", t, 32'(done), 32'(e_done[t]));
    chk("error", t, 32'(error), 32'(e_err[t]));
    chk("err_addr", t, 32'(err_addr), 32'(e_ea[t]));
  endtask

  // Responder reacting to the DUT select; stray ready only where it must be ignored.
  task automatic respond(input int t);
    if (ram_cs) begin
      int d;
      d = (kacc < 512) ? dly[kacc] : 1;
      kacc++;
      paddr = ram_address;
      pwr   = (ram_we != 4'h0);
      if (pwr) mem[ram_address] = ram_write_data;
      pend = (d == 0) ? -1 : t + d;
    end
    ram_ready = (pend == t)
             || (stray_en && ram_cs && $urandom_range(0, 1) == 1)
             || (stray_en && !ram_cs && !e_busy[t] && $urandom_range(0, 3) == 0);
    ram_read_data = (pend == t && !pwr) ? (mem[paddr] ^ corr[paddr]) : $urandom;
  endtask

  task automatic run_sweep(input bit s, input int depth, input logic [31:0] fill,
                           input bit stray, input int abort_at, output int done_at);
    int f;
    sel = s; stray_en = stray; pend = -1; kacc = 0; done_at = -1;
    build_model(depth, fill, f);
    for (int t = 0; t <= f + 3; t++) begin
      @(negedge clk);
      compare(t);
      if (done && done_at < 0) done_at = t;
      if (t == abort_at) begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_busy", t, 32'(busy), 32'h0);
        chk("rst_done", t, 32'(done), 32'h0);
        chk("rst_error", t, 32'(error), 32'h0);
        chk("rst_cs", t, 32'(ram_cs), 32'h0);
        chk("rst_we", t, 32'(ram_we), 32'h0);
        chk("rst_addr", t, 32'(ram_address), 32'h0);
        start_drv = 1'b0; ram_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
          @(negedge clk);
          chk("rst_hold_done", t + i, 32'(done), 32'h0);
          chk("rst_hold_cs", t + i, 32'(ram_cs), 32'h0);
        end
        reset_n = 1'b1;
        m_err[s] = 0; m_ea[s] = 8'h0;
        return;
      end
      respond(t);
      start_drv = (t == 0) || (stray && (t == 5 || t == f));
    end
    start_drv = 1'b0; ram_ready = 1'b0;
  endtask

  task automatic plan_ideal();
    for (int k = 0; k < 512; k++) dly[k] = 1;
    for (int a = 0; a < 256; a++) corr[a] = 32'h0;
  endtask

  initial begin
    int da;
    m_err[0] = 0; m_err[1] = 0; m_ea[0] = 8'h0; m_ea[1] = 8'h0;
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    plan_ideal();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_busy", i, 32'(a_busy), 32'h0);
      chk("reset_cs", i, 32'(a_cs), 32'h0);
      chk("reset_err_addr", i, 32'(a_ea), 32'h0);
      chk("reset_wdata", i, b_wd, 32'h0);
    end
    reset_n = 1'b1;

    // Ideal responder, clean memory
    run_sweep(0, 4, 32'h0, 0, -1, da);
    chk("s1_done_cycle", 0, da, 17);
    chk("s1_error", 0, 32'(error), 32'h0);

    // Corrupted readback of words 2 and 3
    corr[2] = 32'h1; corr[3] = 32'h2;
    run_sweep(0, 4, 32'h0, 0, -1, da);
    chk("s2_done_cycle", 0, da, 17);
    chk("s2_err_addr", 0, 32'(err_addr), 32'h2);

    // No acknowledge after the first write
    plan_ideal(); dly[0] = 0;
    run_sweep(0, 4, 32'h0, 0, -1, da);
    chk("s3_done_cycle", 0, da, 2 + TO);
    chk("s3_error", 0, 32'(error), 32'h1);
    chk("s3_err_addr", 0, 32'(err_addr), 32'h0);

    // Stray start/ready pulses ignored; new start clears the previous error
    plan_ideal();
    run_sweep(0, 4, 32'h0, 1, -1, da);
    chk("s4_done_cycle", 0, da, 17);
    chk("s4_error", 0, 32'(error), 32'h0);

    // Reset during a read wait, then a full sweep
    run_sweep(0, 4, 32'h0, 0, 10, da);
    run_sweep(0, 4, 32'h0, 0, -1, da);
    chk("s5_done_cycle", 0, da, 17);

    // Randomized delays, corruption and stray pulses
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 8; k++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r <= 13)      dly[k] = 1 + (r % 3);
        else if (r <= 15) dly[k] = TO;
        else if (r == 16) dly[k] = TO + 1;
        else if (r == 17) dly[k] = 0;
        else              dly[k] = $urandom_range(4, 14);
      end
      for (int a = 0; a < 4; a++)
        corr[a] = ($urandom_range(0, 4) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      run_sweep(0, 4, 32'h0, 1'($urandom_range(0, 1)), -1, da);
    end

    // Full-size sweep with a non-zero pattern
    plan_ideal();
    run_sweep(1, 256, FILLB, 0, -1, da);
    chk("s7_done_cycle", 0, da, 1025);
    chk("s7_error", 0, 32'(error), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fw_ram_scrubber.md
Name: fw_ram_scrubber

Overview:
- Bus initiator for the FW RAM single-cycle-select / registered-ready port.
- On a start pulse, writes FILL_VALUE to every word (all byte lanes), then reads each word back and checks it.
- Reports busy, done, sticky error and first failing address.
- Sits between the FW-mode control logic and the FW RAM port; the top-level mux routes the RAM port to this block while busy is high.

Parameters:
- ADDR_WIDTH, 8, RAM word-address width.
- DEPTH, 256, number of 32-bit words swept; 2 <= DEPTH <= 2**ADDR_WIDTH.
- FILL_VALUE, 32'h0, pattern written and expected on readback.
- TIMEOUT, 15, max cycles to wait for ram_ready after a select; 4-bit counter, 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- busy  out  1  high from first select until sweep ends.
- done  out  1  one-cycle pulse at end of sweep (pass or fail).
- error  out  1  sticky fail flag; cleared on accepted start.
- err_addr  out  ADDR_WIDTH  address of first failure; cleared on accepted start.
- ram_cs  out  1  select; high exactly one cycle per access.
- ram_we  out  4  byte write enables; 4'hf on write accesses, 4'h0 on reads.
- ram_address  out  ADDR_WIDTH  word address.
- ram_write_data  out  32  FILL_VALUE during write accesses, else 0.
- ram_read_data  in  32  valid in the cycle ram_ready is high.
- ram_ready  in  1  responder acknowledge, nominally one cycle after ram_cs.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE; address counter = 0.
  - All outputs 0: busy, done, error, err_addr, ram_cs, ram_we, ram_address, ram_write_data.
  - Reset mid-sweep aborts immediately. No done pulse is produced.
- All outputs are registered.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH.
- IDLE:
  - start=1 clears error and err_addr, sets addr=0 and goes to WR_REQ.
  - ram_ready is ignored.
- WR_REQ (one cycle):
  - ram_cs=1, ram_we=4'hf, ram_address=addr, ram_write_data=FILL_VALUE.
  - Timeout counter is cleared. Next state is WR_WAIT.
- WR_WAIT:
  - ram_cs=0, ram_we=0.
  - On ram_ready:
    - If addr==DEPTH-1: addr wraps to 0 and the FSM goes to RD_REQ.
    - Otherwise: addr+1 and back to WR_REQ.
- RD_REQ (one cycle):
  - ram_cs=1, ram_we=0, ram_address=addr. Counter cleared. Next state is RD_WAIT.
- RD_WAIT, on ram_ready:
  - Compare ram_read_data to FILL_VALUE.
  - On mismatch with error=0: set error=1 and err_addr=addr. The sweep continues.
  - Later mismatches do not overwrite err_addr.
  - If addr==DEPTH-1, go to FINISH. Otherwise addr+1 and back to RD_REQ.
- Timeout (either WAIT state):
  - Counter increments each cycle without ram_ready.
  - When it reaches TIMEOUT: if error=0, set error=1 and err_addr=addr. Then go to FINISH (sweep aborted).
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- busy is high in WR_REQ through RD_WAIT inclusive.
- Latency with a ready-after-one-cycle responder:
  - start sampled at cycle 0; first ram_cs at cycle 1.
  - Each access takes 2 cycles; busy lasts 4*DEPTH cycles.
  - done is high at cycle 4*DEPTH+1.
- start while not IDLE (including FINISH) is ignored.
- ram_ready with ram_cs high in the same cycle is not counted as an acknowledge. Only WAIT states accept ready.
- The address counter is ADDR_WIDTH bits. The terminal compare against DEPTH-1 ensures no wrap beyond the last word is ever issued.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (3-bit, IDLE=0 … FINISH=5).
  - RAM byte-enable constants WE_ALL=4'hf and WE_NONE=4'h0.
  - The default FILL_VALUE.
- One natural sub-module: fw_ram_scrubber_timeout. It is the 4-bit ready watchdog with clear/enable inputs and an expired output.
- The FSM, address counter and compare stay in the top module.

Test Plan:
- DEPTH=4, ideal responder model (ready = cs delayed 1, memory array): start at cycle 0.
  -> ram_cs high at cycles 1,3,5,7 with we=f and addresses 0..3, then cycles 9,11,13,15 with we=0 and addresses 0..3.
  -> busy high cycles 1..16; done=1 at cycle 17; error=0.
- Same, but the model corrupts word 2 readback to 32'h1 and word 3 to 32'h2.
  -> error=1, err_addr=2, done still pulses at cycle 17.
- The model never asserts ready after the first write.
  -> after 15 wait cycles, error=1, err_addr=0.
  -> done pulses once, no further ram_cs, FSM back in IDLE.
- Start pulsed again at cycle 5 of a sweep.
  -> ignored; sweep timing identical to the first scenario.
  -> A start after done clears error/err_addr and reruns the sweep.
- reset_n low asynchronously mid-RD_WAIT.
  -> all outputs 0 immediately (before the next clk edge), no done pulse.
  -> After release, a new start performs a full sweep from address 0.
- FILL_VALUE=32'hA5A5_5A5A, DEPTH=256 with the ideal responder.
  -> every write carries A5A5_5A5A; done at cycle 1025; error=0.
